// File: rtl/stack_arbiter.sv
// Two-requester round-robin arbiter in front of an external stack: one op in flight, IDLE -> ISSUE -> RESP.
// Optional peek support is enabled by defining STACK_ARBITER_PEEK_EN.
module stack_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0_valid,
    input  logic [1:0]                 req0_op,
    input  logic [WIDTH-1:0]           req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [1:0]                 req1_op,
    input  logic [WIDTH-1:0]           req1_data,
    output logic                       req1_ready,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic                       stk_we,
    output logic [WIDTH-1:0]           stk_wd,
    output logic [1:0]                 stk_delta,
    input  logic [WIDTH-1:0]           stk_rd,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    localparam int DW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t           state_q;
    logic             ptr_q;
    logic             id_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] cap_q;
    logic             err_q;
    logic [DW-1:0]    depth_q;
    logic             ready0_q, ready1_q;
    logic             rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             stk_we_q;
    logic [WIDTH-1:0] stk_wd_q;
    logic [1:0]       stk_delta_q;

    logic grant_d;
    logic push_ok_d, pop_ok_d, peek_ok_d;

    always_comb begin
        grant_d = ptr_q;
        if (req0_valid && !req1_valid)
            grant_d = 1'b0;
        else if (req1_valid && !req0_valid)
            grant_d = 1'b1;
        push_ok_d = (op_q == 2'b01) && (depth_q != DW'(DEPTH));
        pop_ok_d  = (op_q == 2'b10) && (depth_q != '0);
`ifdef STACK_ARBITER_PEEK_EN
        peek_ok_d = (op_q == 2'b11) && (depth_q != '0);
`else
        peek_ok_d = 1'b0;
`endif
    end

    // Outputs are registered, so the ISSUE actions are visible the cycle after ISSUE is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= 2'b00;
            data_q      <= '0;
            cap_q       <= '0;
            err_q       <= 1'b0;
            depth_q     <= '0;
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            stk_we_q    <= 1'b0;
            stk_wd_q    <= '0;
            stk_delta_q <= 2'b00;
        end else begin
            ready0_q    <= 1'b0;
            ready1_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            stk_we_q    <= 1'b0;
            stk_wd_q    <= '0;
            stk_delta_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        id_q    <= grant_d;
                        op_q    <= grant_d ? req1_op : req0_op;
                        data_q  <= grant_d ? req1_data : req0_data;
                        ptr_q   <= ~grant_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ready0_q <= ~id_q;
                    ready1_q <= id_q;
                    err_q    <= ~(push_ok_d | pop_ok_d | peek_ok_d);
                    cap_q    <= (pop_ok_d | peek_ok_d) ? stk_rd : '0;
                    if (push_ok_d) begin
                        stk_we_q    <= 1'b1;
                        stk_wd_q    <= data_q;
                        stk_delta_q <= 2'b01;
                        depth_q     <= depth_q + DW'(1);
                    end else if (pop_ok_d) begin
                        stk_delta_q <= 2'b11;
                        depth_q     <= depth_q - DW'(1);
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_data_q  <= cap_q;
                    rsp_err_q   <= err_q;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign stk_we     = stk_we_q;
    assign stk_wd     = stk_wd_q;
    assign stk_delta  = stk_delta_q;
    assign depth      = depth_q;
    assign full       = (depth_q == DW'(DEPTH));
    assign empty      = (depth_q == '0);
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural stack model on the stk_* port.
module tb_stack_arbiter;
    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]       req0_op = 2'b00, req1_op = 2'b00;
    logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic             stk_we;
    logic [WIDTH-1:0] stk_wd;
    logic [1:0]       stk_delta;
    logic [WIDTH-1:0] stk_rd;
    logic [DW-1:0]    depth;
    logic             full, empty;

    int vectors = 0;
    int miscompares = 0;

    stack_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stk_we(stk_we), .stk_wd(stk_wd), .stk_delta(stk_delta), .stk_rd(stk_rd),
        .depth(depth), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // External stack: delta 01 pushes stk_wd, 11 pops, stk_rd shows the top word.
    logic [WIDTH-1:0] mem [0:31];
    logic [5:0]       sp = '0;
    always @(posedge clk) begin
        if (reset)
            sp <= '0;
        else if (stk_delta == 2'b01 && stk_we) begin
            mem[sp[4:0]] <= stk_wd;
            sp <= sp + 6'd1;
        end else if (stk_delta == 2'b11 && sp != 0)
            sp <= sp - 6'd1;
    end
    assign stk_rd = (sp != 0) ? mem[5'(sp - 6'd1)] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [WIDTH-1:0] r_data, wd_at;
    logic             r_err, r_id, we_at, dseen, bad;
    logic [1:0]       d_at;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_op(input logic id, input logic [1:0] op, input logic [WIDTH-1:0] data);
        int lat_rdy, lat_rsp;
        lat_rdy = -1; lat_rsp = -1; dseen = 1'b0; bad = 1'b0;
        r_data = 'x; r_err = 1'bx; r_id = 1'bx; d_at = 2'bxx; we_at = 1'bx; wd_at = 'x;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_data = data; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_data = data; end
        for (int c = 1; c <= 12 && lat_rsp < 0; c++) begin
            @(posedge clk); #1;
            if (stk_delta != 2'b00) dseen = 1'b1;
            if (id ? req0_ready : req1_ready) bad = 1'b1;
            if (id ? req1_ready : req0_ready) begin
                lat_rdy = c; d_at = stk_delta; we_at = stk_we; wd_at = stk_wd;
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            if (rsp_valid) begin
                lat_rsp = c; r_data = rsp_data; r_err = rsp_err; r_id = rsp_id;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("ready_latency", lat_rdy, 2);
        chk("rsp_latency", lat_rsp, 3);
        chk("foreign_ready", bad, 0);
        chk("rsp_id", r_id, id);
    endtask

    int   ng;
    logic order [0:3];
    logic both, seen;

    initial begin
        // reset state
        do_reset();
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_data}, 0);
        chk("rst_stk", {stk_we, stk_delta, stk_wd}, 0);

        // LIFO order through req0
        run_op(0, 2'b01, 16'h0001);
        chk("push1_we", we_at, 1);
        chk("push1_wd", wd_at, 16'h0001);
        chk("push1_delta", d_at, 2'b01);
        chk("push1_err", r_err, 0);
        chk("push1_data", r_data, 0);
        run_op(0, 2'b01, 16'h0002);
        run_op(0, 2'b01, 16'h0003);
        chk("depth3", depth, 3);
        run_op(0, 2'b10, 16'h0000);
        chk("pop3_data", r_data, 16'h0003);
        chk("pop3_err", r_err, 0);
        chk("pop3_delta", d_at, 2'b11);
        chk("pop3_we", we_at, 0);
        run_op(0, 2'b10, 16'h0000);
        chk("pop2_data", r_data, 16'h0002);
        run_op(0, 2'b10, 16'h0000);
        chk("pop1_data", r_data, 16'h0001);
        chk("pop1_err", r_err, 0);
        chk("depth0", depth, 0);
        chk("empty0", empty, 1);

        // underflow then overflow
        run_op(0, 2'b10, 16'h0000);
        chk("underflow_err", r_err, 1);
        chk("underflow_delta", dseen, 0);
        chk("underflow_depth", depth, 0);
        for (int i = 0; i < DEPTH; i++) begin
            run_op(0, 2'b01, 16'(16'h0100 + i));
            chk("fill_err", r_err, 0);
        end
        chk("fill_depth", depth, DEPTH);
        chk("fill_full", full, 1);
        run_op(0, 2'b01, 16'hBEEF);
        chk("overflow_err", r_err, 1);
        chk("overflow_delta", dseen, 0);
        chk("overflow_depth", depth, DEPTH);
        chk("overflow_full", full, 1);
        run_op(1, 2'b10, 16'h0000);
        chk("top_after_fill", r_data, 16'h010F);

        // round robin with both requesters holding valid
        do_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = 16'h0010;
        req1_valid = 1'b1; req1_op = 2'b01; req1_data = 16'h0020;
        ng = 0; both = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(posedge clk); #1;
            if (req0_ready && req1_ready) both = 1'b1;
            if (req0_ready) begin order[ng] = 1'b0; ng++; end
            else if (req1_ready) begin order[ng] = 1'b1; ng++; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rr_grants", ng, 4);
        chk("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);
        chk("rr_both_ready", both, 0);
        chk("rr_depth", depth, 4);
        run_op(0, 2'b10, 16'h0000);
        chk("rr_top", r_data, 16'h0020);

        // reset during ISSUE aborts the push
        do_reset();
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_data = 16'h0055;
        @(posedge clk); #1;
        req0_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", {req0_ready, req1_ready}, 0);
        chk("abort_depth", depth, 0);
        chk("abort_stk", {stk_we, stk_delta}, 0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid || req0_ready || req1_ready || stk_delta != 2'b00) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        run_op(0, 2'b01, 16'h0066);
        chk("abort_recover_depth", depth, 1);

        // peek
        do_reset();
        run_op(0, 2'b01, 16'h00AA);
        run_op(0, 2'b11, 16'h0000);
`ifdef STACK_ARBITER_PEEK_EN
        chk("peek_data", r_data, 16'h00AA);
        chk("peek_err", r_err, 0);
`else
        chk("peek_data", r_data, 16'h0000);
        chk("peek_err", r_err, 1);
`endif
        chk("peek_delta", dseen, 0);
        chk("peek_depth", depth, 1);

        // reserved op from req1
        run_op(1, 2'b00, 16'h1234);
        chk("op00_err", r_err, 1);
        chk("op00_delta", dseen, 0);
        chk("op00_depth", depth, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
